gps_ch_wb_sequencer: RTL and testbench
======================================

// Module: gps_ch_wb_sequencer
// PURPOSE
//  Wishbone master that sequences one gps_multichannel tracking channel: programs the six config regs,
//  polls STATUS until bit0 (dump ready) sets, reads the six I/Q accumulators, then clears the flag.
//  Sits between the host/firmware side and the channel slave port; replaces hand-driven bus cycles.
// PARAMETERS
//  CH_BASE_ADDR  32'h00000A00  channel register base (CH2 = 32'h00000B00)
//  POLL_GAP      4             idle wb_clk_i cycles between consecutive STATUS reads
//  MAX_POLLS     16'hFFFF      STATUS reads before giving up (poll timeout)
//  ACK_TIMEOUT   64            cycles waiting for wb_ack_i before bus error
// PORTS
//  wb_clk_i     in   1   bus/sequencer clock
//  wb_rst_i     in   1   asynchronous reset, active-high
//  start_i      in   1   1-cycle pulse: begin full sequence (ignored unless busy_o=0)
//  code_freq_i  in   32  CODE_FREQUENCY word (+0x00)
//  carr_freq_i  in   32  CARR_FREQUENCY word (+0x04)
//  code_off_i   in   32  CODE_FREQUENCY_OFFSET (+0x08)
//  carr_off_i   in   32  CARR_FREQUENCY_OFFSET (+0x0C)
//  acq_thr_i    in   32  ACQ_THRESHOLD (+0x10)
//  confg_i      in   32  CONFG: SV id / LUT select (+0x14)
//  wb_adr_o     out  32  bus address;  wb_dat_o out 32 write data;  wb_sel_o out 4 byte enables (always 4'hF)
//  wb_we_o      out  1   write enable;  wb_cyc_o out 1;  wb_stb_o out 1
//  wb_dat_i     in   32  read data;     wb_ack_i in 1 slave acknowledge
//  dip_o,dqp_o  out  32  prompt I/Q (+0x18/+0x1C)
//  dil_o,dql_o  out  32  late I/Q (+0x20/+0x24)
//  die_o,dqe_o  out  32  early I/Q (+0x28/+0x2C)
//  busy_o       out  1   sequence in progress
//  done_o       out  1   1-cycle pulse: accumulators valid and flag cleared
//  err_o        out  2   sticky until next start_i: 01 ack timeout, 10 poll timeout
// BEHAVIOUR
//  Reset: all outputs 0 (wb_sel_o=0), state IDLE, counters 0. Reset mid-cycle drops cyc/stb immediately.
//  States: IDLE -> CFG(6 writes) -> POLL -> GAP -> (POLL | RD) ; RD(6 reads) -> CLR -> DONE -> IDLE.
//  CFG order: +0x04, +0x00, +0x10, +0x14, +0x0C, +0x08; data from inputs sampled at start_i.
//  Bus cycle: cyc/stb/adr/dat/we driven the cycle after state entry, held stable until wb_ack_i;
//   deasserted the cycle after ack; >=1 idle cycle between transactions; no pipelining/bursts.
//  Read data captured on the ack cycle. POLL reads +0x30 into rs; rs[0]=1 -> RD, else GAP.
//  GAP counts POLL_GAP cycles then POLL; poll counter increments per read, ==MAX_POLLS -> err_o=10, IDLE.
//  RD order: +0x18,+0x1C,+0x28,+0x2C,+0x20,+0x24 into dip,dqp,die,dqe,dil,dql (held until next RD).
//  CLR writes +0x30 with {rs[31:1], ~rs[0]}; DONE pulses done_o for 1 cycle.
//  Ack counter resets per transaction; reaching ACK_TIMEOUT drops cyc/stb, err_o=01, IDLE, no done_o.
//  start_i while busy_o=1: ignored. start_i same cycle as error exit: ignored (IDLE next cycle).
//  wb_ack_i while cyc=0: ignored. busy_o=1 from cycle after start_i through DONE inclusive.
// CONFIGURATION
//  GPS_SEQ_CONTINUOUS_EN defined: after DONE, return to POLL (no reconfig) and keep dumping every epoch
//   until start_i is pulsed again, which acts as stop (finish current transaction, go IDLE, no done_o).
//  Undefined: single shot, DONE -> IDLE; start_i during busy ignored.
// TESTING
//  1 Config: start_i with code=16EA4A8C, carr=0, thr=2710, confg=1409A1BE -> six writes in stated
//    order/addresses 0xA04,0xA00,0xA10,0xA14,0xA0C,0xA08 with matching data, sel=F.
//  2 Poll: slave STATUS=0 for 3 reads then 1 -> exactly 4 reads of 0xA30, >=4 idle cycles apart,
//    then reads 0xA18..0xA24 in stated order; dip..dql equal slave values; CLR writes bit0=0; done_o 1 cycle.
//  3 Ack stretch: slave delays ack 10 cycles -> signals stable throughout, sequence completes;
//    no ack for 64 cycles -> cyc/stb low, err_o=01, busy_o=0, done_o never pulses.
//  4 Poll timeout: MAX_POLLS=8, STATUS stuck 0 -> 8 reads, err_o=10, IDLE; next start_i clears err_o.
//  5 Reset mid-RD: assert wb_rst_i during 3rd accumulator read -> cyc/stb/busy/outputs 0 same cycle;
//    subsequent start_i runs clean sequence.
//  6 With GPS_SEQ_CONTINUOUS_EN: STATUS sets twice -> two done_o pulses, no CFG writes between;
//    start_i then -> IDLE after current ack, no third done_o.

Source files
------------

// File: rtl/gps_ch_wb_sequencer.sv
// rtl/gps_ch_wb_sequencer.sv - Wishbone master sequencing one GPS tracking channel: config, STATUS poll, I/Q dump, flag clear.
// Optional GPS_SEQ_CONTINUOUS_EN: re-poll after each dump until start_i is pulsed again (stop).
module gps_ch_wb_sequencer #(
    parameter logic [31:0] CH_BASE_ADDR = 32'h00000A00,
    parameter int          POLL_GAP     = 4,
    parameter logic [15:0] MAX_POLLS    = 16'hFFFF,
    parameter int          ACK_TIMEOUT  = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] code_freq_i,
    input  logic [31:0] carr_freq_i,
    input  logic [31:0] code_off_i,
    input  logic [31:0] carr_off_i,
    input  logic [31:0] acq_thr_i,
    input  logic [31:0] confg_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [31:0] dip_o,
    output logic [31:0] dqp_o,
    output logic [31:0] dil_o,
    output logic [31:0] dql_o,
    output logic [31:0] die_o,
    output logic [31:0] dqe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_POLL, S_GAP, S_RD, S_CLR, S_DONE
    } state_t;

    state_t            r_state;
    logic [2:0]        r_idx;
    logic [5:0][31:0]  r_cfg;
    logic [31:0]       r_rs;
    logic [15:0]       r_polls;
    logic [15:0]       r_gap;
    logic [15:0]       r_ack_cnt;
    logic              r_cyc, r_stb, r_we;
    logic [31:0]       r_adr, r_dat;
    logic [3:0]        r_sel;
    logic [31:0]       r_dip, r_dqp, r_dil, r_dql, r_die, r_dqe;
    logic              r_busy, r_done;
    logic [1:0]        r_err;

    logic [7:0]        w_off;
    logic [31:0]       w_wdat;
    logic              w_we;
    logic [31:0]       w_adr;
    logic              w_stop;

`ifdef GPS_SEQ_CONTINUOUS_EN
    logic r_stop;
    assign w_stop = r_stop | (r_busy & start_i);
`else
    assign w_stop = 1'b0;
`endif

    // r_cfg is held in bus write order, so CFG step r_idx simply picks entry r_idx
    always_comb begin
        w_off  = 8'h00;
        w_wdat = 32'h0;
        w_we   = 1'b0;
        case (r_state)
            S_CFG: begin
                w_we   = 1'b1;
                w_wdat = r_cfg[r_idx];
                case (r_idx)
                    3'd0:    w_off = 8'h04;
                    3'd1:    w_off = 8'h00;
                    3'd2:    w_off = 8'h10;
                    3'd3:    w_off = 8'h14;
                    3'd4:    w_off = 8'h0C;
                    default: w_off = 8'h08;
                endcase
            end
            S_POLL: w_off = 8'h30;
            S_RD: begin
                case (r_idx)
                    3'd0:    w_off = 8'h18;
                    3'd1:    w_off = 8'h1C;
                    3'd2:    w_off = 8'h28;
                    3'd3:    w_off = 8'h2C;
                    3'd4:    w_off = 8'h20;
                    default: w_off = 8'h24;
                endcase
            end
            S_CLR: begin
                w_off  = 8'h30;
                w_we   = 1'b1;
                w_wdat = {r_rs[31:1], ~r_rs[0]};
            end
            default: ;
        endcase
    end

    assign w_adr = CH_BASE_ADDR + {24'h0, w_off};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_cfg     <= '0;
            r_rs      <= 32'h0;
            r_polls   <= 16'h0;
            r_gap     <= 16'h0;
            r_ack_cnt <= 16'h0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_sel     <= 4'h0;
            r_dip     <= 32'h0;
            r_dqp     <= 32'h0;
            r_dil     <= 32'h0;
            r_dql     <= 32'h0;
            r_die     <= 32'h0;
            r_dqe     <= 32'h0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 2'b00;
`ifdef GPS_SEQ_CONTINUOUS_EN
            r_stop    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_sel  <= 4'hF;
`ifdef GPS_SEQ_CONTINUOUS_EN
            if (r_busy && start_i) r_stop <= 1'b1;
`endif
            case (r_state)
                S_IDLE: begin
`ifdef GPS_SEQ_CONTINUOUS_EN
                    r_stop <= 1'b0;
`endif
                    if (start_i) begin
                        r_cfg   <= {code_off_i, carr_off_i, confg_i, acq_thr_i, code_freq_i, carr_freq_i};
                        r_err   <= 2'b00;
                        r_busy  <= 1'b1;
                        r_idx   <= 3'd0;
                        r_polls <= 16'h0;
                        r_gap   <= 16'h0;
                        r_state <= S_CFG;
                    end
                end
                S_GAP: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gap == 16'(POLL_GAP - 1)) begin
                        r_gap   <= 16'h0;
                        r_state <= S_POLL;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
                S_DONE: begin
`ifdef GPS_SEQ_CONTINUOUS_EN
                    if (w_stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_polls <= 16'h0;
                        r_state <= S_POLL;
                    end
`else
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                default: begin
                    if (r_cyc) begin
                        if (wb_ack_i) begin
                            r_cyc <= 1'b0;
                            r_stb <= 1'b0;
                            r_we  <= 1'b0;
                            r_adr <= 32'h0;
                            r_dat <= 32'h0;
                            r_idx <= r_idx + 3'd1;
                            case (r_state)
                                S_CFG: begin
                                    if (r_idx == 3'd5) begin
                                        r_idx   <= 3'd0;
                                        r_state <= S_POLL;
                                    end
                                end
                                S_POLL: begin
                                    r_idx   <= 3'd0;
                                    r_rs    <= wb_dat_i;
                                    r_polls <= r_polls + 16'd1;
                                    if (wb_dat_i[0]) begin
                                        r_state <= S_RD;
                                    end else if (r_polls + 16'd1 == MAX_POLLS) begin
                                        r_err   <= 2'b10;
                                        r_busy  <= 1'b0;
                                        r_state <= S_IDLE;
                                    end else begin
                                        r_state <= S_GAP;
                                    end
                                end
                                S_RD: begin
                                    case (r_idx)
                                        3'd0:    r_dip <= wb_dat_i;
                                        3'd1:    r_dqp <= wb_dat_i;
                                        3'd2:    r_die <= wb_dat_i;
                                        3'd3:    r_dqe <= wb_dat_i;
                                        3'd4:    r_dil <= wb_dat_i;
                                        default: r_dql <= wb_dat_i;
                                    endcase
                                    if (r_idx == 3'd5) begin
                                        r_idx   <= 3'd0;
                                        r_state <= S_CLR;
                                    end
                                end
                                default: begin
                                    r_idx   <= 3'd0;
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end
                            endcase
                            // a pending stop wins over whatever the completed transaction chose
                            if (w_stop) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b0;
                            end
                        end else if (r_ack_cnt == 16'(ACK_TIMEOUT - 1)) begin
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_adr   <= 32'h0;
                            r_dat   <= 32'h0;
                            r_err   <= 2'b01;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_ack_cnt <= r_ack_cnt + 16'd1;
                        end
                    end else if (w_stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                        r_we      <= w_we;
                        r_adr     <= w_adr;
                        r_dat     <= w_wdat;
                        r_ack_cnt <= 16'h0;
                    end
                end
            endcase
        end
    end

    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign dip_o    = r_dip;
    assign dqp_o    = r_dqp;
    assign dil_o    = r_dil;
    assign dql_o    = r_dql;
    assign die_o    = r_die;
    assign dqe_o    = r_dqe;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign err_o    = r_err;

endmodule

// File: tb/tb_gps_ch_wb_sequencer.sv
// tb/tb_gps_ch_wb_sequencer.sv - self-checking bench for gps_ch_wb_sequencer with a Wishbone slave model and transaction scoreboard.
module tb_gps_ch_wb_sequencer;

    localparam logic [31:0] B       = 32'h00000A00;
    localparam int          GAP     = 4;
    localparam logic [30:0] STAT_HI = 31'h2AB4C0D1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] code_freq_i = '0, carr_freq_i = '0, code_off_i = '0;
    logic [31:0] carr_off_i = '0, acq_thr_i = '0, confg_i = '0;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic [31:0] dip_o, dqp_o, dil_o, dql_o, die_o, dqe_o;
    logic        busy_o, done_o;
    logic [1:0]  err_o;

    always #5 clk = ~clk;

    gps_ch_wb_sequencer #(
        .CH_BASE_ADDR(B), .POLL_GAP(GAP), .MAX_POLLS(16'd8), .ACK_TIMEOUT(64)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i),
        .code_freq_i(code_freq_i), .carr_freq_i(carr_freq_i), .code_off_i(code_off_i),
        .carr_off_i(carr_off_i), .acq_thr_i(acq_thr_i), .confg_i(confg_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .dip_o(dip_o), .dqp_o(dqp_o), .dil_o(dil_o), .dql_o(dql_o), .die_o(die_o), .dqe_o(dqe_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0]      code, carr, code_off, carr_off, thr, confg;
        int               nzero;
        int               ack_dly;
        logic [15:0]      seed;
        logic [5:0][31:0] acc;   // 0..5 = +0x18 dip, dqp, dil, dql, die, dqe
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    vec_t vecs[3];
    txn_t exp_q[$];
    txn_t cur;
    int   n_vec = 0, n_fail = 0;

    logic [5:0][31:0] s_acc;
    int  s_left = 0, s_reload = 0, s_dly = 0;
    bit  free_run = 0;
    int  done_cnt = 0, abort_len = 0, idle = 100, wcnt = 0;
    bit  in_txn = 0, cur_ok = 0, bad = 0, cur_poll = 0, last_poll = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic void push(input bit we, input logic [7:0] off, input logic [31:0] d);
        txn_t t;
        t.we  = we;
        t.adr = B + {24'h0, off};
        t.dat = d;
        exp_q.push_back(t);
    endfunction

    function automatic void push_cfg(input vec_t v);
        push(1, 8'h04, v.carr);
        push(1, 8'h00, v.code);
        push(1, 8'h10, v.thr);
        push(1, 8'h14, v.confg);
        push(1, 8'h0C, v.carr_off);
        push(1, 8'h08, v.code_off);
    endfunction

    function automatic void push_epoch(input int nzero);
        for (int k = 0; k <= nzero; k++) push(0, 8'h30, 32'h0);
        push(0, 8'h18, 32'h0);
        push(0, 8'h1C, 32'h0);
        push(0, 8'h28, 32'h0);
        push(0, 8'h2C, 32'h0);
        push(0, 8'h20, 32'h0);
        push(0, 8'h24, 32'h0);
        push(1, 8'h30, {STAT_HI, 1'b0});
    endfunction

    // Slave model plus bus monitor in one negedge process so ack and checks never race.
    initial begin
        int k;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (rst) begin
                wb_ack_i = 1'b0;
                in_txn   = 0;
                idle     = 100;
            end else if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                if (in_txn) begin
                    in_txn    = 0;
                    n_vec++;
                    last_poll = cur_poll;
                end
                idle = wb_cyc_o ? 0 : 1;
            end else if (wb_cyc_o) begin
                if (!in_txn) begin
                    in_txn   = 1;
                    wcnt     = 0;
                    bad      = 0;
                    cur_ok   = (exp_q.size() != 0);
                    cur_poll = (wb_adr_o == B + 32'h30) && !wb_we_o;
                    if (cur_ok) cur = exp_q.pop_front();
                    else if (!free_run) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_txn: adr=%h we=%b", wb_adr_o, wb_we_o);
                    end
                    chk("idle_gap_ok", (idle >= ((cur_poll && last_poll) ? GAP : 1)), 1);
                end
                if (cur_ok && !bad && ((wb_adr_o !== cur.adr) || (wb_we_o !== cur.we) ||
                    (cur.we && (wb_dat_o !== cur.dat)) || (wb_sel_o !== 4'hF) || (wb_stb_o !== 1'b1))) begin
                    bad = 1;
                    n_fail++;
                    $display("FAIL txn: adr=%h we=%b dat=%h sel=%h stb=%b required adr=%h we=%b dat=%h",
                             wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o, wb_stb_o, cur.adr, cur.we, cur.dat);
                end
                if (wcnt >= s_dly) begin
                    wb_ack_i = 1'b1;
                    if (!wb_we_o) begin
                        if (wb_adr_o == B + 32'h30) begin
                            if (s_left > 0) begin
                                wb_dat_i = {STAT_HI, 1'b0};
                                s_left--;
                            end else begin
                                wb_dat_i = {STAT_HI, 1'b1};
                            end
                        end else begin
                            k = (int'(wb_adr_o[7:0]) - 'h18) / 4;
                            wb_dat_i = (k >= 0 && k < 6) ? s_acc[k] : 32'hBAD0BAD0;
                        end
                    end else if (wb_adr_o == B + 32'h30) begin
                        s_left = s_reload;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                if (in_txn) begin
                    in_txn    = 0;
                    abort_len = wcnt;
                end
                idle++;
            end
        end
    end

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        code_freq_i = v.code;
        carr_freq_i = v.carr;
        code_off_i  = v.code_off;
        carr_off_i  = v.carr_off;
        acq_thr_i   = v.thr;
        confg_i     = v.confg;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit got = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy_o) begin
                got = 1;
                break;
            end
        end
        chk(nm, got, 1);
    endtask

    task automatic run_seq(input vec_t v, input bit extra);
        bit got = 0;
        s_acc     = v.acc;
        s_left    = v.nzero;
        s_reload  = v.nzero;
        s_dly     = v.ack_dly;
        last_poll = 0;
        push_cfg(v);
        push_epoch(v.nzero);
        drive_start(v);
        chk("busy_after_start", busy_o, 1);
        chk("err_clear_on_start", err_o, 0);
        if (extra) begin
            repeat (12) @(negedge clk);
            code_freq_i = 32'hDEADBEEF;
            start_i     = 1'b1;
            @(negedge clk);
            start_i     = 1'b0;
        end
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("busy_at_done", busy_o, 1);
            chk("dip", dip_o, v.acc[0]);
            chk("dqp", dqp_o, v.acc[1]);
            chk("dil", dil_o, v.acc[2]);
            chk("dql", dql_o, v.acc[3]);
            chk("die", die_o, v.acc[4]);
            chk("dqe", dqe_o, v.acc[5]);
        end
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
        chk("busy_after_done", busy_o, 0);
        chk("err_after_done", err_o, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int  d0;
        bit  got;
        vec_t v;

        vecs[0] = '{code:32'h16EA4A8C, carr:32'h00000000, code_off:32'h00000040, carr_off:32'hFFFFFC18,
                    thr:32'h00002710, confg:32'h1409A1BE, nzero:3, ack_dly:0, seed:16'h1A2B, acc:'0};
        vecs[1] = '{code:32'h12345678, carr:32'h0A0B0C0D, code_off:32'h00000001, carr_off:32'h00000002,
                    thr:32'h00001388, confg:32'h00000003, nzero:0, ack_dly:10, seed:16'hC3E1, acc:'0};
        vecs[2] = '{code:32'hCAFEF00D, carr:32'h80000001, code_off:32'h7FFFFFFF, carr_off:32'h55AA55AA,
                    thr:32'h00000001, confg:32'hFFFFFFFF, nzero:7, ack_dly:2, seed:16'h0F0F, acc:'0};
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 6; k++)
                vecs[i].acc[k] = {vecs[i].seed + 16'(k), ~vecs[i].seed - 16'(k * 3)};

        repeat (3) @(negedge clk);
        chk("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_status", {busy_o, done_o, err_o}, 0);
        chk("rst_acc", dip_o | dqp_o | dil_o | dql_o | die_o | dqe_o, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifndef GPS_SEQ_CONTINUOUS_EN
        for (int i = 0; i < 3; i++) run_seq(vecs[i], i == 1);

        // ack never arrives: first CFG write must be abandoned with err 01
        s_dly = 1000000;
        d0    = done_cnt;
        push(1, 8'h04, vecs[0].carr);
        drive_start(vecs[0]);
        wait_idle("ackto_exit", 300);
        @(negedge clk);
        chk("ackto_err", err_o, 2'b01);
        chk("ackto_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
        chk("ackto_len_ok", (abort_len >= 63 && abort_len <= 65), 1);
        repeat (5) @(negedge clk);
        chk("ackto_no_done", done_cnt - d0, 0);
        chk("ackto_queue", exp_q.size(), 0);
        s_dly = 0;

        // STATUS stuck at 0: exactly MAX_POLLS reads then err 10
        s_left   = 1000;
        s_reload = 1000;
        last_poll = 0;
        d0 = done_cnt;
        push_cfg(vecs[2]);
        for (int k = 0; k < 8; k++) push(0, 8'h30, 32'h0);
        drive_start(vecs[2]);
        chk("ackto_err_cleared", err_o, 0);
        wait_idle("pto_exit", 1000);
        @(negedge clk);
        chk("pto_err", err_o, 2'b10);
        chk("pto_queue", exp_q.size(), 0);
        chk("pto_no_done", done_cnt - d0, 0);

        // reset while the third accumulator read is on the bus
        s_acc    = vecs[0].acc;
        s_left   = 2;
        s_reload = 2;
        last_poll = 0;
        push_cfg(vecs[0]);
        for (int k = 0; k < 3; k++) push(0, 8'h30, 32'h0);
        push(0, 8'h18, 32'h0);
        push(0, 8'h1C, 32'h0);
        push(0, 8'h28, 32'h0);
        drive_start(vecs[0]);
        chk("pto_err_cleared", err_o, 0);
        got = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_adr_o == B + 32'h28) begin
                got = 1;
                break;
            end
        end
        chk("rd3_reached", got, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 0);
        chk("midrst_status", {busy_o, done_o, err_o}, 0);
        chk("midrst_acc", dip_o | dqp_o | dil_o | dql_o | die_o | dqe_o, 0);
        chk("midrst_adr", wb_adr_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        run_seq(vecs[1], 0);
`else
        // continuous: two dumps without reconfiguration, then start_i stops it
        v        = vecs[0];
        s_acc    = v.acc;
        s_left   = 1;
        s_reload = 1;
        s_dly    = 0;
        last_poll = 0;
        d0       = done_cnt;
        push_cfg(v);
        push_epoch(1);
        push_epoch(1);
        drive_start(v);
        got = 0;
        for (int c = 0, nd = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done_o) nd++;
            if (nd == 2) begin
                got = 1;
                free_run = 1;
                break;
            end
        end
        chk("cont_two_done", got, 1);
        chk("cont_queue", exp_q.size(), 0);
        chk("cont_dip", dip_o, v.acc[0]);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle("cont_stop", 300);
        repeat (20) @(negedge clk);
        chk("cont_no_third_done", done_cnt - d0, 2);
        chk("cont_cyc_low", wb_cyc_o, 0);
        chk("cont_busy_low", busy_o, 0);
        free_run = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
